// File: rtl/test_sequencer_pkg.sv
// rtl/test_sequencer_pkg.sv - opcodes, fail codes, FSM states and instruction lengths for test_sequencer
package test_sequencer_pkg;

    localparam logic [3:0] OP_SET   = 4'd1;
    localparam logic [3:0] OP_WAIT  = 4'd2;
    localparam logic [3:0] OP_PAUSE = 4'd3;
    localparam logic [3:0] OP_WIN   = 4'd4;
    localparam logic [3:0] OP_WAITM = 4'd5;
    localparam logic [3:0] OP_LOOP  = 4'd6;
    localparam logic [3:0] OP_ENDL  = 4'd7;
    localparam logic [3:0] OP_FAIL  = 4'd8;

    localparam logic [3:0] FC_NONE       = 4'd0;
    localparam logic [3:0] FC_TIMEOUT    = 4'd1;
    localparam logic [3:0] FC_BAD_OP     = 4'd2;
    localparam logic [3:0] FC_LOOP_FULL  = 4'd3;
    localparam logic [3:0] FC_LOOP_EMPTY = 4'd4;
    localparam logic [3:0] FC_FAIL_OP    = 4'd5;
    localparam logic [3:0] FC_BUS_ERR    = 4'd6;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_ARG,
        S_EXEC,
        S_WRITE,
        S_POLL,
        S_PAUSE,
        S_SUCCESS,
        S_FAIL
    } seq_state_e;

    // Total words per instruction including the opcode word.
    function automatic logic [2:0] instr_len(input logic [3:0] op);
        case (op)
            OP_SET:             return 3'd3;
            OP_WAIT, OP_WAITM:  return 3'd5;
            OP_PAUSE, OP_LOOP:  return 3'd2;
            default:            return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/seq_timeout_timer.sv
// rtl/seq_timeout_timer.sv - prescaled tick counter that flags when ticks reach the timeout value
module seq_timeout_timer #(
    parameter int DIVISOR = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        enable_i,
    input  logic [15:0] tmo_i,
    output logic        expired_o
);
    localparam int PW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIVISOR - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   ticks_q, ticks_d;

    always_comb begin
        presc_d = presc_q;
        ticks_d = ticks_q;
        if (clear_i) begin
            presc_d = '0;
            ticks_d = '0;
        end else if (enable_i) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                ticks_d = ticks_q + 16'd1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            ticks_q <= '0;
        end else begin
            presc_q <= presc_d;
            ticks_q <= ticks_d;
        end
    end

    assign expired_o = (ticks_q >= tmo_i);

endmodule

// File: rtl/test_sequencer.sv
// rtl/test_sequencer.sv - Wishbone master running a word-coded test program with loops, polls and fail diagnostics
module test_sequencer
    import test_sequencer_pkg::*;
#(
    parameter int          DATA_WIDTH            = 16,
    parameter int          ADDRESS_WIDTH         = 24,
    parameter int unsigned PROGMEM_START         = 'h10000,
    parameter int          TIMEOUT_CLOCK_DIVISOR = 1,
    parameter int          LOOP_DEPTH            = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ADDRESS_WIDTH-1:0] wbAdrO,
    output logic [DATA_WIDTH-1:0]    wbDatO,
    input  logic [DATA_WIDTH-1:0]    wbDatI,
    output logic                     wbCycO,
    output logic                     wbStbO,
    output logic                     wbWeO,
    input  logic                     wbAckI,
    input  logic                     wbErrI,
    input  logic [15:0]              controlReg,
    output logic [15:0]              statusReg,
    output logic [ADDRESS_WIDTH-1:0] failAddr
);
    localparam int DW  = DATA_WIDTH;
    localparam int AW  = ADDRESS_WIDTH;
    localparam int SPW = $clog2(LOOP_DEPTH + 1);
    localparam int IW  = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;
    localparam logic [AW-1:0]  IP_START = AW'(PROGMEM_START);
    localparam logic [SPW-1:0] SP_FULL  = SPW'(LOOP_DEPTH);

    function automatic logic [AW-1:0] to_addr(input logic [DW-1:0] w);
        logic [AW+DW-1:0] wide;
        wide = {{AW{1'b0}}, w};
        return wide[AW-1:0];
    endfunction

    seq_state_e      state_q, state_d;
    logic [AW-1:0]   ip_q, ip_d;
    logic [3:0]      op_q, op_d;
    logic [AW-1:0]   op_adr_q, op_adr_d;
    logic [DW-1:0]   arg_q [4];
    logic [DW-1:0]   arg_d [4];
    logic [1:0]      arg_idx_q, arg_idx_d;
    logic [3:0]      fail_code_q, fail_code_d;
    logic [AW-1:0]   fail_addr_q, fail_addr_d;
    logic [AW-1:0]   stk_start_q [LOOP_DEPTH];
    logic [AW-1:0]   stk_start_d [LOOP_DEPTH];
    logic [15:0]     stk_cnt_q [LOOP_DEPTH];
    logic [15:0]     stk_cnt_d [LOOP_DEPTH];
    logic [SPW-1:0]  sp_q, sp_d;

    logic            cyc_q, cyc_d, we_q, we_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   dat_q, dat_d;

    logic            halt, start, bus_ack, bus_err, expired, tmr_clear, tmr_enable, match;
    logic [15:0]     tmo, loop_cnt;
    logic [2:0]      fetch_len, nargs;
    logic [IW-1:0]   top_idx, push_idx;
    logic            unused_ctrl;

    assign halt        = controlReg[0];
    assign start       = controlReg[1];
    assign unused_ctrl = ^controlReg[15:2];
    assign bus_ack     = cyc_q & wbAckI;
    assign bus_err     = cyc_q & wbErrI;
    assign fetch_len   = instr_len(wbDatI[3:0]);
    assign nargs       = instr_len(op_q) - 3'd1;
    assign top_idx     = IW'(sp_q - 1'b1);
    assign push_idx    = IW'(sp_q);
    assign loop_cnt    = (arg_q[0][15:0] == 16'd0) ? 16'd1 : arg_q[0][15:0];
    assign tmo         = (op_q == OP_PAUSE) ? arg_q[0][15:0] : arg_q[3][15:0];
    assign tmr_clear   = halt || (state_q == S_EXEC);
    assign tmr_enable  = (state_q == S_POLL) || (state_q == S_PAUSE);

    always_comb begin
        match = 1'b0;
        if (op_q == OP_WAITM) begin
            match = ((wbDatI & arg_q[1]) == (arg_q[2] & arg_q[1]));
        end else begin
            match = (wbDatI >= arg_q[1]) && (wbDatI <= arg_q[2]);
        end
    end

    seq_timeout_timer #(
        .DIVISOR (TIMEOUT_CLOCK_DIVISOR)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (tmr_clear),
        .enable_i  (tmr_enable),
        .tmo_i     (tmo),
        .expired_o (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ip_q        <= IP_START;
            op_q        <= '0;
            op_adr_q    <= '0;
            arg_idx_q   <= '0;
            fail_code_q <= FC_NONE;
            fail_addr_q <= '0;
            sp_q        <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            for (int i = 0; i < 4; i++) arg_q[i] <= '0;
            for (int i = 0; i < LOOP_DEPTH; i++) begin
                stk_start_q[i] <= '0;
                stk_cnt_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            ip_q        <= ip_d;
            op_q        <= op_d;
            op_adr_q    <= op_adr_d;
            arg_idx_q   <= arg_idx_d;
            fail_code_q <= fail_code_d;
            fail_addr_q <= fail_addr_d;
            sp_q        <= sp_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            arg_q       <= arg_d;
            stk_start_q <= stk_start_d;
            stk_cnt_q   <= stk_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ip_d        = ip_q;
        op_d        = op_q;
        op_adr_d    = op_adr_q;
        arg_d       = arg_q;
        arg_idx_d   = arg_idx_q;
        fail_code_d = fail_code_q;
        fail_addr_d = fail_addr_q;
        stk_start_d = stk_start_q;
        stk_cnt_d   = stk_cnt_q;
        sp_d        = sp_q;

        if (bus_err) begin
            state_d     = S_FAIL;
            fail_code_d = FC_BUS_ERR;
        end else begin
            case (state_q)
                S_IDLE: if (start) state_d = S_FETCH;
                S_FETCH: if (bus_ack) begin
                    if (wbDatI == '0 || wbDatI > DW'(OP_FAIL)) begin
                        state_d     = S_FAIL;
                        fail_code_d = FC_BAD_OP;
                    end else begin
                        op_d      = wbDatI[3:0];
                        op_adr_d  = ip_q;
                        ip_d      = ip_q + AW'(fetch_len);
                        arg_idx_d = '0;
                        state_d   = (fetch_len > 3'd1) ? S_ARG : S_EXEC;
                    end
                end
                S_ARG: if (bus_ack) begin
                    arg_d[arg_idx_q] = wbDatI;
                    if ({1'b0, arg_idx_q} == nargs - 3'd1) state_d = S_EXEC;
                    else arg_idx_d = arg_idx_q + 2'd1;
                end
                S_EXEC: begin
                    case (op_q)
                        OP_SET:            state_d = S_WRITE;
                        OP_WAIT, OP_WAITM: state_d = S_POLL;
                        OP_PAUSE:          state_d = S_PAUSE;
                        OP_WIN:            state_d = S_SUCCESS;
                        OP_LOOP: begin
                            if (sp_q == SP_FULL) begin
                                state_d     = S_FAIL;
                                fail_code_d = FC_LOOP_FULL;
                            end else begin
                                stk_start_d[push_idx] = ip_q;
                                stk_cnt_d[push_idx]   = loop_cnt;
                                sp_d    = sp_q + 1'b1;
                                state_d = S_FETCH;
                            end
                        end
                        OP_ENDL: begin
                            if (sp_q == '0) begin
                                state_d     = S_FAIL;
                                fail_code_d = FC_LOOP_EMPTY;
                            end else if (stk_cnt_q[top_idx] > 16'd1) begin
                                stk_cnt_d[top_idx] = stk_cnt_q[top_idx] - 16'd1;
                                ip_d    = stk_start_q[top_idx];
                                state_d = S_FETCH;
                            end else begin
                                sp_d    = sp_q - 1'b1;
                                state_d = S_FETCH;
                            end
                        end
                        default: begin
                            state_d     = S_FAIL;
                            fail_code_d = FC_FAIL_OP;
                        end
                    endcase
                end
                S_WRITE: if (bus_ack) state_d = S_FETCH;
                // A match on the same Ack as expiry still counts as a pass.
                S_POLL: if (bus_ack) begin
                    if (match) begin
                        state_d = S_FETCH;
                    end else if (expired) begin
                        state_d     = S_FAIL;
                        fail_code_d = FC_TIMEOUT;
                    end
                end
                S_PAUSE: if (expired) state_d = S_FETCH;
                default: state_d = state_q;
            endcase
        end

        if (state_d == S_FAIL && state_q != S_FAIL) begin
            fail_addr_d = (state_q == S_FETCH) ? ip_q : op_adr_q;
        end

        if (halt) begin
            state_d     = S_IDLE;
            ip_d        = IP_START;
            op_d        = '0;
            op_adr_d    = '0;
            arg_idx_d   = '0;
            fail_code_d = FC_NONE;
            fail_addr_d = '0;
            sp_d        = '0;
        end
    end

    // Bus registers: a new access starts only once the previous one has been retired.
    always_comb begin
        cyc_d = cyc_q;
        we_d  = we_q;
        adr_d = adr_q;
        dat_d = dat_q;
        if (halt) begin
            cyc_d = 1'b0;
            we_d  = 1'b0;
            adr_d = '0;
            dat_d = '0;
        end else if (cyc_q) begin
            if (wbAckI || wbErrI) begin
                cyc_d = 1'b0;
                we_d  = 1'b0;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    cyc_d = 1'b1;
                    adr_d = ip_q;
                end
                S_ARG: begin
                    cyc_d = 1'b1;
                    adr_d = op_adr_q + AW'(arg_idx_q) + AW'(1);
                end
                S_WRITE: begin
                    cyc_d = 1'b1;
                    we_d  = 1'b1;
                    adr_d = to_addr(arg_q[0]);
                    dat_d = arg_q[1];
                end
                S_POLL: begin
                    cyc_d = 1'b1;
                    adr_d = to_addr(arg_q[0]);
                end
                default: cyc_d = 1'b0;
            endcase
        end
    end

    always_comb begin
        wbCycO    = cyc_q;
        wbStbO    = cyc_q;
        wbWeO     = we_q;
        wbAdrO    = adr_q;
        wbDatO    = dat_q;
        failAddr  = fail_addr_q;
        statusReg = {9'd0, fail_code_q,
                     (state_q != S_IDLE) && (state_q != S_SUCCESS) && (state_q != S_FAIL),
                     state_q == S_FAIL, state_q == S_SUCCESS};
    end

endmodule

// File: tb/tb_test_sequencer.sv
// tb/tb_test_sequencer.sv - scoreboard bench for test_sequencer with a program/register slave model
module tb_test_sequencer;
    localparam int DW = 16;
    localparam int AW = 24;
    localparam logic [AW-1:0] PSTART = 24'h010000;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] wbAdrO;
    logic [DW-1:0] wbDatO, wbDatI;
    logic          wbCycO, wbStbO, wbWeO, wbAckI, wbErrI;
    logic [15:0]   controlReg, statusReg;
    logic [AW-1:0] failAddr;

    logic [15:0]   prog [0:63];
    logic [15:0]   poll_first, poll_rest;
    logic          err_on_write;
    int            total = 0;
    int            bad = 0;
    int            clr_gen = 0;
    int            seen_gen = 0;
    int            poll_reads = 0;
    logic          pend = 1'b0;
    logic [AW-1:0] obs_adr [$];
    logic [DW-1:0] obs_dat [$];
    logic [AW-1:0] exp_adr [$];
    logic [DW-1:0] exp_dat [$];

    test_sequencer #(
        .DATA_WIDTH            (DW),
        .ADDRESS_WIDTH         (AW),
        .PROGMEM_START         ('h10000),
        .TIMEOUT_CLOCK_DIVISOR (2),
        .LOOP_DEPTH            (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wbAdrO     (wbAdrO),
        .wbDatO     (wbDatO),
        .wbDatI     (wbDatI),
        .wbCycO     (wbCycO),
        .wbStbO     (wbStbO),
        .wbWeO      (wbWeO),
        .wbAckI     (wbAckI),
        .wbErrI     (wbErrI),
        .controlReg (controlReg),
        .statusReg  (statusReg),
        .failAddr   (failAddr)
    );

    always #5 clk = ~clk;

    assign wbAckI = wbCycO && wbStbO && !(err_on_write && wbWeO);
    assign wbErrI = wbCycO && wbStbO && err_on_write && wbWeO;

    always_comb begin
        logic [AW-1:0] off;
        off = wbAdrO - PSTART;
        if (wbAdrO >= PSTART && off < 24'd64) wbDatI = prog[off[5:0]];
        else wbDatI = (poll_reads == 0) ? poll_first : poll_rest;
    end

    // Register reads are counted one cycle late so the returned data is stable through its Ack.
    always @(negedge clk) begin
        if (clr_gen != seen_gen) begin
            seen_gen   <= clr_gen;
            poll_reads <= 0;
            pend       <= 1'b0;
            obs_adr.delete();
            obs_dat.delete();
        end else begin
            if (pend) poll_reads <= poll_reads + 1;
            pend <= wbCycO && wbAckI && !wbWeO && (wbAdrO < PSTART);
            if (wbCycO && wbAckI && wbWeO) begin
                obs_adr.push_back(wbAdrO);
                obs_dat.push_back(wbDatO);
            end
        end
    end

    task automatic new_prog();
        for (int i = 0; i < 64; i++) prog[i] = 16'h0000;
        exp_adr.delete();
        exp_dat.delete();
        poll_first   = 16'h0000;
        poll_rest    = 16'h0000;
        err_on_write = 1'b0;
        controlReg   = 16'h0001;
        repeat (2) @(negedge clk);
        controlReg = 16'h0000;
        clr_gen++;
        @(negedge clk);
    endtask

    task automatic expect_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_adr.push_back(a);
        exp_dat.push_back(d);
    endtask

    task automatic run_prog(input string name);
        logic done;
        done = 1'b0;
        controlReg = 16'h0002;
        for (int n = 0; n < 3000 && !done; n++) begin
            @(negedge clk);
            if (statusReg[1:0] != 2'b00) done = 1'b1;
        end
        controlReg = 16'h0000;
        repeat (3) @(negedge clk);
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s_finish: status=%h never reached a terminal state", name, statusReg);
        end
    endtask

    task automatic test_reset();
        total++;
        if (statusReg !== 16'h0000) begin bad++; $display("FAIL reset_status: got %h want 0000", statusReg); end
        total++;
        if ({wbCycO, wbStbO, wbWeO} !== 3'b000) begin bad++; $display("FAIL reset_bus: got %b want 000", {wbCycO, wbStbO, wbWeO}); end
        total++;
        if (failAddr !== 24'h0 || wbAdrO !== 24'h0) begin bad++; $display("FAIL reset_addr: got %h/%h want 0/0", failAddr, wbAdrO); end
    endtask

    task automatic test_set_win();
        new_prog();
        prog[0] = 16'h0001; prog[1] = 16'h0005; prog[2] = 16'hBEEF; prog[3] = 16'h0004;
        expect_write(24'h000005, 16'hBEEF);
        run_prog("set_win");
        total++;
        if (statusReg !== 16'h0001) begin bad++; $display("FAIL set_win_status: got %h want 0001", statusReg); end
        total++;
        if (obs_adr.size() != exp_adr.size()) begin bad++; $display("FAIL set_win_count: got %0d want %0d", obs_adr.size(), exp_adr.size()); end
        foreach (exp_adr[i]) if (i < obs_adr.size()) begin
            total++;
            if (obs_adr[i] !== exp_adr[i] || obs_dat[i] !== exp_dat[i]) begin
                bad++; $display("FAIL set_win_write%0d: got %h<=%h want %h<=%h", i, obs_adr[i], obs_dat[i], exp_adr[i], exp_dat[i]);
            end
        end
    endtask

    task automatic test_wait();
        new_prog();
        prog[0] = 16'h0002; prog[1] = 16'h0003; prog[2] = 16'd10; prog[3] = 16'd20; prog[4] = 16'd4;
        prog[5] = 16'h0001; prog[6] = 16'h0009; prog[7] = 16'h1111; prog[8] = 16'h0004;
        poll_first = 16'd7; poll_rest = 16'd15;
        expect_write(24'h000009, 16'h1111);
        run_prog("wait");
        total++;
        if (statusReg !== 16'h0001) begin bad++; $display("FAIL wait_status: got %h want 0001", statusReg); end
        total++;
        if (poll_reads != 2) begin bad++; $display("FAIL wait_reads: got %0d want 2", poll_reads); end
        total++;
        if (obs_adr.size() != 1 || obs_adr[0] !== exp_adr[0] || obs_dat[0] !== exp_dat[0]) begin
            bad++; $display("FAIL wait_next_write: got %0d writes want 1 of %h<=%h", obs_adr.size(), exp_adr[0], exp_dat[0]);
        end

        new_prog();
        prog[0] = 16'h0002; prog[1] = 16'h0003; prog[2] = 16'd10; prog[3] = 16'd20; prog[4] = 16'd0;
        poll_first = 16'd30; poll_rest = 16'd30;
        run_prog("wait_tmo0");
        total++;
        if (statusReg !== 16'h000A) begin bad++; $display("FAIL wait_tmo0_status: got %h want 000a", statusReg); end
        total++;
        if (poll_reads != 1) begin bad++; $display("FAIL wait_tmo0_reads: got %0d want 1", poll_reads); end
    endtask

    task automatic test_waitm();
        new_prog();
        prog[0] = 16'h0001; prog[1] = 16'h0002; prog[2] = 16'h00AA;
        prog[3] = 16'h0005; prog[4] = 16'h0003; prog[5] = 16'h00F0; prog[6] = 16'h0030; prog[7] = 16'd3;
        poll_first = 16'h1204; poll_rest = 16'h1204;
        expect_write(24'h000002, 16'h00AA);
        run_prog("waitm_tmo");
        total++;
        if (statusReg !== 16'h000A) begin bad++; $display("FAIL waitm_tmo_status: got %h want 000a", statusReg); end
        total++;
        if (failAddr !== 24'h010003) begin bad++; $display("FAIL waitm_tmo_failaddr: got %h want 010003", failAddr); end
        total++;
        if (poll_reads < 3 || poll_reads > 5) begin bad++; $display("FAIL waitm_tmo_reads: got %0d want 3..5", poll_reads); end
        total++;
        if (obs_adr.size() != 1 || obs_adr[0] !== exp_adr[0] || obs_dat[0] !== exp_dat[0]) begin
            bad++; $display("FAIL waitm_tmo_write: got %0d writes want 1 of %h<=%h", obs_adr.size(), exp_adr[0], exp_dat[0]);
        end

        new_prog();
        prog[0] = 16'h0005; prog[1] = 16'h0003; prog[2] = 16'h00F0; prog[3] = 16'h0030; prog[4] = 16'd3; prog[5] = 16'h0004;
        poll_first = 16'h1234; poll_rest = 16'h1234;
        run_prog("waitm_match");
        total++;
        if (statusReg !== 16'h0001 || poll_reads != 1) begin
            bad++; $display("FAIL waitm_match: got status %h reads %0d want 0001 reads 1", statusReg, poll_reads);
        end
    endtask

    task automatic test_loop();
        logic [15:0] cnts [2];
        int          nw [2];
        cnts[0] = 16'd3; cnts[1] = 16'd0;
        nw[0] = 3; nw[1] = 1;
        for (int t = 0; t < 2; t++) begin
            new_prog();
            prog[0] = 16'h0006; prog[1] = cnts[t];
            prog[2] = 16'h0001; prog[3] = 16'h0001; prog[4] = 16'(t + 1);
            prog[5] = 16'h0007; prog[6] = 16'h0004;
            for (int k = 0; k < nw[t]; k++) expect_write(24'h000001, 16'(t + 1));
            run_prog("loop");
            total++;
            if (statusReg !== 16'h0001) begin bad++; $display("FAIL loop%0d_status: got %h want 0001", t, statusReg); end
            total++;
            if (obs_adr.size() != exp_adr.size()) begin bad++; $display("FAIL loop%0d_count: got %0d want %0d", t, obs_adr.size(), exp_adr.size()); end
            foreach (exp_adr[i]) if (i < obs_adr.size()) begin
                total++;
                if (obs_adr[i] !== exp_adr[i] || obs_dat[i] !== exp_dat[i]) begin
                    bad++; $display("FAIL loop%0d_write%0d: got %h<=%h want %h<=%h", t, i, obs_adr[i], obs_dat[i], exp_adr[i], exp_dat[i]);
                end
            end
        end
    endtask

    task automatic test_fail_codes();
        logic [15:0] want_st;
        logic [AW-1:0] want_fa;
        for (int c = 0; c < 5; c++) begin
            new_prog();
            case (c)
                0: begin for (int k = 0; k < 5; k++) begin prog[2*k] = 16'h0006; prog[2*k+1] = 16'd1; end
                         want_st = 16'h001A; want_fa = 24'h010008; end
                1: begin prog[0] = 16'h0007; want_st = 16'h0022; want_fa = 24'h010000; end
                2: begin prog[0] = 16'h0001; prog[1] = 16'h0004; prog[2] = 16'h0001; prog[3] = 16'h00FF;
                         expect_write(24'h000004, 16'h0001); want_st = 16'h0012; want_fa = 24'h010003; end
                3: begin prog[0] = 16'h0003; prog[1] = 16'd0; prog[2] = 16'h0008; want_st = 16'h002A; want_fa = 24'h010002; end
                default: begin prog[0] = 16'h0001; prog[1] = 16'h0005; prog[2] = 16'hBEEF; prog[3] = 16'h0004;
                         err_on_write = 1'b1; want_st = 16'h0032; want_fa = 24'h010000; end
            endcase
            run_prog("fail_code");
            total++;
            if (statusReg !== want_st) begin bad++; $display("FAIL fail%0d_status: got %h want %h", c, statusReg, want_st); end
            total++;
            if (failAddr !== want_fa) begin bad++; $display("FAIL fail%0d_failaddr: got %h want %h", c, failAddr, want_fa); end
            total++;
            if (obs_adr.size() != exp_adr.size()) begin bad++; $display("FAIL fail%0d_writes: got %0d want %0d", c, obs_adr.size(), exp_adr.size()); end
        end
    endtask

    task automatic test_pause();
        new_prog();
        prog[0] = 16'h0003; prog[1] = 16'd0; prog[2] = 16'h0003; prog[3] = 16'd4;
        prog[4] = 16'h0001; prog[5] = 16'h0007; prog[6] = 16'h0077; prog[7] = 16'h0004;
        expect_write(24'h000007, 16'h0077);
        run_prog("pause");
        total++;
        if (statusReg !== 16'h0001) begin bad++; $display("FAIL pause_status: got %h want 0001", statusReg); end
        total++;
        if (obs_adr.size() != 1 || obs_adr[0] !== exp_adr[0] || obs_dat[0] !== exp_dat[0]) begin
            bad++; $display("FAIL pause_write: got %0d writes want 1 of %h<=%h", obs_adr.size(), exp_adr[0], exp_dat[0]);
        end
    endtask

    task automatic test_async_reset();
        new_prog();
        prog[0] = 16'h0002; prog[1] = 16'h0003; prog[2] = 16'd10; prog[3] = 16'd20; prog[4] = 16'd100;
        controlReg = 16'h0002;
        repeat (12) @(negedge clk);
        total++;
        if (statusReg !== 16'h0004) begin bad++; $display("FAIL rst_mid_running: got %h want 0004", statusReg); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (statusReg !== 16'h0000 || {wbCycO, wbStbO, wbWeO} !== 3'b000 || wbAdrO !== 24'h0) begin
            bad++; $display("FAIL rst_async: got status %h bus %b adr %h want 0000 000 000000", statusReg, {wbCycO, wbStbO, wbWeO}, wbAdrO);
        end
        controlReg = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        new_prog();
        prog[0] = 16'h0001; prog[1] = 16'h000C; prog[2] = 16'h5A5A; prog[3] = 16'h0004;
        expect_write(24'h00000C, 16'h5A5A);
        run_prog("rst_restart");
        total++;
        if (statusReg !== 16'h0001) begin bad++; $display("FAIL rst_restart_status: got %h want 0001", statusReg); end
        total++;
        if (obs_adr.size() != 1 || obs_adr[0] !== exp_adr[0] || obs_dat[0] !== exp_dat[0]) begin
            bad++; $display("FAIL rst_restart_write: got %0d writes want 1 of %h<=%h", obs_adr.size(), exp_adr[0], exp_dat[0]);
        end
    endtask

    initial begin
        rst = 1'b1;
        controlReg = 16'h0000;
        poll_first = 16'h0000;
        poll_rest = 16'h0000;
        err_on_write = 1'b0;
        for (int i = 0; i < 64; i++) prog[i] = 16'h0000;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_set_win();
        test_wait();
        test_waitm();
        test_loop();
        test_fail_codes();
        test_pause();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
